// File: rtl/vga_capture.sv
// vga_capture
//   Receive-side counterpart of the VGA timing generator. Samples the sync
//   and pixel inputs, rebuilds the generator's column/line position from the
//   sync falling edges and emits one frame-buffer write per active pixel.
//   Write addresses are column-major: h*VACTIVE + v.
//
// Ports:
//   clock        pixel clock (same domain as the generator)
//   reset        synchronous, active-high
//   vga_hsync    horizontal sync, active low
//   vga_vsync    vertical sync, active low
//   vga_rgb      3-bit pixel data
//   wr_en        frame-buffer write strobe
//   wr_addr      write address (ADDR_W bits)
//   wr_data      pixel data to write
//   frame_start  one-cycle pulse alongside the write of address 0
//   locked       high while column and line tracking are both aligned
//   timing_err   one-cycle pulse on a sync edge at an unexpected position
//   err_count    saturating count of timing errors
//
// Build option:
//   VGA_CAPTURE_CHECK_EN  when defined, sync edges are checked against the
//                         predicted position while locked; mismatches pulse
//                         timing_err, bump err_count and drop lock. When
//                         undefined, edges only realign the counters and
//                         timing_err/err_count stay 0.

module vga_capture #(
    parameter int HACTIVE = 640,
    parameter int HFP     = 16,
    parameter int HSYNC   = 96,
    parameter int HBP     = 48,
    parameter int VACTIVE = 480,
    parameter int VFP     = 10,
    parameter int VSYNC   = 2,
    parameter int VBP     = 33,
    parameter int ADDR_W  = 19
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              vga_hsync,
    input  logic              vga_vsync,
    input  logic [2:0]        vga_rgb,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [2:0]        wr_data,
    output logic              frame_start,
    output logic              locked,
    output logic              timing_err,
    output logic [7:0]        err_count
);

    localparam int HTOTAL = HACTIVE + HFP + HSYNC + HBP;
    localparam int VTOTAL = VACTIVE + VFP + VSYNC + VBP;
    localparam int HW     = $clog2(HTOTAL);
    localparam int VW     = $clog2(VTOTAL);

    localparam logic [HW-1:0] H_ACT   = HW'(HACTIVE);
    localparam logic [HW-1:0] H_LAST  = HW'(HTOTAL - 1);
    localparam logic [HW-1:0] H_ALIGN = HW'(HACTIVE + HFP);
    localparam logic [VW-1:0] V_ACT   = VW'(VACTIVE);
    localparam logic [VW-1:0] V_LAST  = VW'(VTOTAL - 1);
    localparam logic [VW-1:0] V_ALIGN = VW'(VACTIVE + VFP);

    typedef enum logic [1:0] {
        ST_UNLOCKED,
        ST_SEEK_V,
        ST_LOCKED
    } state_t;

    state_t        state;
    logic          hs_r;
    logic          vs_r;
    logic [2:0]    rgb_r;
    logic [HW-1:0] h_pos;
    logic [VW-1:0] v_pos;

    logic          hfall;
    logic          vfall;
    logic [HW-1:0] h_pred;
    logic [HW-1:0] h_next;
    logic [VW-1:0] v_pred;
    logic [VW-1:0] v_next;
    logic          active;
    logic [ADDR_W-1:0] addr_calc;

    // h_pos/v_pos describe the sample currently held in rgb_r, so the
    // realignment values are the generator position at which each sync
    // pulse starts.
    always_comb begin
        hfall  = !vga_hsync && hs_r;
        vfall  = !vga_vsync && vs_r;
        h_pred = (h_pos == H_LAST) ? '0 : h_pos + HW'(1);
        h_next = hfall ? H_ALIGN : h_pred;
        // line advance follows the (possibly realigned) column wrap
        v_pred = v_pos;
        if (h_next == '0) begin
            v_pred = (v_pos == V_LAST) ? '0 : v_pos + VW'(1);
        end
        v_next    = vfall ? V_ALIGN : v_pred;
        active    = locked && (h_pos < H_ACT) && (v_pos < V_ACT);
        addr_calc = ADDR_W'(h_pos) * ADDR_W'(VACTIVE) + ADDR_W'(v_pos);
    end

`ifdef VGA_CAPTURE_CHECK_EN
    logic err;

    always_comb begin
        err = (state == ST_LOCKED) &&
              ((hfall && (h_pred != H_ALIGN)) || (vfall && (v_pred != V_ALIGN)));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            timing_err <= 1'b0;
            err_count  <= '0;
        end else begin
            timing_err <= err;
            if (err && (err_count != '1)) begin
                err_count <= err_count + 8'd1;
            end
        end
    end
`else
    assign timing_err = 1'b0;
    assign err_count  = '0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_UNLOCKED;
            locked      <= 1'b0;
            hs_r        <= 1'b1;
            vs_r        <= 1'b1;
            rgb_r       <= '0;
            h_pos       <= '0;
            v_pos       <= '0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            frame_start <= 1'b0;
        end else begin
            hs_r  <= vga_hsync;
            vs_r  <= vga_vsync;
            rgb_r <= vga_rgb;
            h_pos <= h_next;
            v_pos <= v_next;

            wr_en       <= active;
            wr_addr     <= active ? addr_calc : '0;
            wr_data     <= active ? rgb_r : '0;
            frame_start <= active && (h_pos == '0) && (v_pos == '0);

            case (state)
                ST_UNLOCKED: begin
                    if (hfall) begin
                        state <= ST_SEEK_V;
                    end
                end
                ST_SEEK_V: begin
                    if (vfall) begin
                        state  <= ST_LOCKED;
                        locked <= 1'b1;
                    end
                end
                ST_LOCKED: begin
`ifdef VGA_CAPTURE_CHECK_EN
                    if (err) begin
                        state  <= ST_SEEK_V;
                        locked <= 1'b0;
                    end
`endif
                end
                default: begin
                    state  <= ST_UNLOCKED;
                    locked <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_capture.sv
// tb_vga_capture
//   Directed bench for vga_capture using a reduced timing (32x20 total,
//   16x12 active) so whole frames stay short. A generator model drives the
//   sync/pixel inputs; each output cycle is judged against the generator
//   position applied one tick earlier (two clocks of input-to-output delay).

module tb_vga_capture;

    localparam int HA  = 16;
    localparam int HFP = 8;
    localparam int HS  = 4;
    localparam int HBP = 4;
    localparam int VA  = 12;
    localparam int VFP = 3;
    localparam int VS  = 2;
    localparam int VBP = 3;
    localparam int AW  = 8;
    localparam int HT  = HA + HFP + HS + HBP;
    localparam int VT  = VA + VFP + VS + VBP;
    localparam int GL  = 5;

    logic          clock = 1'b0;
    logic          reset;
    logic          vga_hsync;
    logic          vga_vsync;
    logic [2:0]    vga_rgb;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [2:0]    wr_data;
    logic          frame_start;
    logic          locked;
    logic          timing_err;
    logic [7:0]    err_count;

    always #20 clock = ~clock;

    vga_capture #(
        .HACTIVE(HA), .HFP(HFP), .HSYNC(HS), .HBP(HBP),
        .VACTIVE(VA), .VFP(VFP), .VSYNC(VS), .VBP(VBP),
        .ADDR_W(AW)
    ) dut (
        .clock(clock), .reset(reset),
        .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_rgb(vga_rgb),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .frame_start(frame_start), .locked(locked),
        .timing_err(timing_err), .err_count(err_count)
    );

    int vectors = 0;
    int miscompares = 0;

    // generator state and the position applied on the previous tick
    int gh, gv, ph, pv;
    bit sync_hi;
    int glitch_line;
    // 0: no writes, 1: full frame, 2: lock lost after line GL,
    // 3: realigned line GL (don't care on the shifted span)
    int mode;
    int n_good, n_bad, n_fs, n_fsbad, n_unlk, n_terr;

    task automatic check_eq(input string tag, input int obs, input int exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_write(input int h, input int v);
        case (mode)
            1: return int'(h < HA && v < VA);
            2: return int'(h < HA && v <= GL);
            3: begin
                if ((v == GL && h >= HA) || v == GL + 1) return 2;
                return int'(h < HA && v < VA);
            end
            default: return 0;
        endcase
    endfunction

    task automatic clear_stats();
        n_good = 0; n_bad = 0; n_fs = 0; n_fsbad = 0; n_unlk = 0; n_terr = 0;
    endtask

    task automatic observe(input int h, input int v);
        int e;
        e = exp_write(h, v);
        if (e == 1) begin
            if (wr_en === 1'b1 && wr_addr === AW'(h * VA + v) && wr_data === 3'((h + v) % 8))
                n_good++;
            else
                n_bad++;
        end else if (e == 0 && wr_en !== 1'b0) begin
            n_bad++;
        end
        if (frame_start === 1'b1) begin
            n_fs++;
            if (!(h == 0 && v == 0 && wr_en === 1'b1)) n_fsbad++;
        end
        if (locked !== 1'b1) n_unlk++;
        if (timing_err === 1'b1) n_terr++;
    endtask

    task automatic tick();
        bit hlow, vlow;
        hlow = (gh >= HA + HFP && gh < HA + HFP + HS) ||
               (gv == glitch_line && gh >= HA + HFP - 5 && gh < HA + HFP);
        vlow = (gv >= VA + VFP && gv < VA + VFP + VS);
        vga_hsync = sync_hi ? 1'b1 : !hlow;
        vga_vsync = sync_hi ? 1'b1 : !vlow;
        vga_rgb   = 3'((gh + gv) % 8);
        @(posedge clock);
        #1;
        observe(ph, pv);
        ph = gh;
        pv = gv;
        if (gh == HT - 1) begin
            gh = 0;
            gv = (gv == VT - 1) ? 0 : gv + 1;
        end else begin
            gh++;
        end
    endtask

    task automatic run_to(input int h, input int v);
        int n;
        n = 0;
        while (!(gh == h && gv == v) && n < 2 * HT * VT) begin
            tick();
            n++;
        end
        if (!(gh == h && gv == v)) check_eq("run_to_timeout", n, 0);
    endtask

    task automatic run_frame();
        repeat (HT * VT) tick();
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_wr_en"}, int'(wr_en), 0);
        check_eq({tag, "_wr_addr"}, int'(wr_addr), 0);
        check_eq({tag, "_wr_data"}, int'(wr_data), 0);
        check_eq({tag, "_frame_start"}, int'(frame_start), 0);
        check_eq({tag, "_locked"}, int'(locked), 0);
        check_eq({tag, "_timing_err"}, int'(timing_err), 0);
        check_eq({tag, "_err_count"}, int'(err_count), 0);
    endtask

    task automatic check_full_frame(input string tag);
        check_eq({tag, "_writes"}, n_good, HA * VA);
        check_eq({tag, "_bad"}, n_bad, 0);
        check_eq({tag, "_fs"}, n_fs, 1);
        check_eq({tag, "_fs_bad"}, n_fsbad, 0);
    endtask

    initial begin
        reset = 1'b1; sync_hi = 1'b1; glitch_line = -1; mode = 0;
        gh = 0; gv = 0; ph = HT - 1; pv = VT - 1;
        vga_hsync = 1'b1; vga_vsync = 1'b1; vga_rgb = '0;
        clear_stats();
        tick();
        tick();
        check_all_zero("reset");

        // lock-up and a full frame
        reset = 1'b0; sync_hi = 1'b0; gh = 0; gv = 0;
        run_to(0, VA + VFP);
        check_eq("lock_before_vfall", int'(locked), 0);
        tick();
        check_eq("lock_after_vfall", int'(locked), 1);
        run_to(0, 0);
        mode = 1; clear_stats();
        run_frame();
        check_full_frame("frame2");
        check_eq("frame2_unlocked", n_unlk, 0);

        // latency of pixel (0,0)
        tick();
        check_eq("lat_early_wr_en", int'(wr_en), 0);
        tick();
        check_eq("lat_wr_en", int'(wr_en), 1);
        check_eq("lat_wr_addr", int'(wr_addr), 0);
        check_eq("lat_frame_start", int'(frame_start), 1);
        check_eq("lat_wr_data", int'(wr_data), 0);
        run_to(0, 0);

        // early hsync on line GL
        glitch_line = GL;
`ifdef VGA_CAPTURE_CHECK_EN
        mode = 2;
`else
        mode = 3;
`endif
        clear_stats();
        run_to(0, 10);
`ifdef VGA_CAPTURE_CHECK_EN
        check_eq("glitch_locked", int'(locked), 0);
`else
        check_eq("glitch_locked", int'(locked), 1);
`endif
        run_to(0, 0);
        glitch_line = -1;
        check_eq("glitch_bad", n_bad, 0);
`ifdef VGA_CAPTURE_CHECK_EN
        check_eq("glitch_terr", n_terr, 1);
        check_eq("glitch_err_count", int'(err_count), 1);
        check_eq("glitch_writes", n_good, HA * (GL + 1));
`else
        check_eq("glitch_terr", n_terr, 0);
        check_eq("glitch_err_count", int'(err_count), 0);
        check_eq("glitch_writes", n_good, HA * (VA - 1));
        check_eq("glitch_unlocked", n_unlk, 0);
`endif
        mode = 1; clear_stats();
        run_frame();
        check_full_frame("post_glitch");

        // reset mid-frame while locked
        run_to(10, 6);
        mode = 0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_all_zero("midreset");
        clear_stats();
        run_to(0, VA + VFP - 1);
        check_eq("midreset_locked", int'(locked), 0);
        run_to(0, 0);
        check_eq("midreset_no_writes", n_bad, 0);
        mode = 1; clear_stats();
        run_frame();
        check_full_frame("post_reset");

        // sync held high after reset, then resumed
        reset = 1'b1; sync_hi = 1'b1; mode = 0;
        tick();
        reset = 1'b0;
        clear_stats();
        repeat (2 * HT * VT) tick();
        check_eq("synchi_unlocked", n_unlk, 2 * HT * VT);
        check_eq("synchi_no_writes", n_bad, 0);
        sync_hi = 1'b0; gh = 0; gv = 0;
        run_to(0, VA + VFP);
        check_eq("resume_lock_before", int'(locked), 0);
        tick();
        check_eq("resume_lock_after", int'(locked), 1);
        run_to(0, 0);
        mode = 1; clear_stats();
        run_frame();
        check_full_frame("resume");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
